// File: rtl/dma_pkg.sv
// Shared definitions for the memory copy engine: sign masks, state encoding,
// memory map constants and pointer helpers.
package dma_pkg;

    localparam logic [3:0]  SM_WORD    = 4'b0111;
    localparam logic [3:0]  SM_HALF    = 4'b0011;
    localparam logic [3:0]  SM_BYTE    = 4'b0001;

    localparam logic [31:0] DATA_BASE  = 32'h0000_0000;
    localparam logic [31:0] LED_ADDR   = 32'h0000_2000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR_ISSUE = 3'd3,
        ST_WR_WAIT  = 3'd4,
        ST_FIN      = 3'd5
    } dma_state_e;

    function automatic logic [31:0] ptr_step(input logic [31:0] ptr, input logic descend);
        logic [31:0] res;
        if (descend) begin
            res = ptr - WORD_BYTES;
        end else begin
            res = ptr + WORD_BYTES;
        end
        return res;
    endfunction

    function automatic logic word_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/mem_copy_dma_if.sv
// Data-memory initiator port: request, address/data out, read data and stall in.
interface mem_copy_dma_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data;
    logic        mem_clk_stall;

    modport master (
        output mem_addr, mem_write_data, mem_memwrite, mem_memread, mem_sign_mask,
        input  mem_read_data, mem_clk_stall
    );

    modport slave (
        input  mem_addr, mem_write_data, mem_memwrite, mem_memread, mem_sign_mask,
        output mem_read_data, mem_clk_stall
    );
endinterface

// File: rtl/mem_port_req.sv
// Single-request handshake shared by read and write phases: issue on idle memory,
// wait for the stall pulse to come and go, and time out if it never comes.
module mem_port_req
    import dma_pkg::*;
#(
    parameter int WDOG = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic issue_en,
    input  logic wait_en,
    input  logic mem_clk_stall,
    output logic req,
    output logic complete,
    output logic timeout
);

    localparam int CNT_W = (WDOG < 2) ? 1 : $clog2(WDOG);

    logic             seen_hi_r;
    logic [CNT_W-1:0] quiet_cnt_r;
    logic             quiet_s;

    // Handshake decode from the current phase and the live stall line
    always_comb begin
        req      = issue_en & ~mem_clk_stall;
        quiet_s  = wait_en & ~seen_hi_r & ~mem_clk_stall;
        complete = wait_en & seen_hi_r & ~mem_clk_stall;
        timeout  = quiet_s & (quiet_cnt_r == CNT_W'(WDOG - 1));
    end

    // Stall-seen flag and quiet-cycle watchdog, rearmed by every issue
    always_ff @(posedge clk) begin
        if (reset) begin
            seen_hi_r   <= 1'b0;
            quiet_cnt_r <= {CNT_W{1'b0}};
        end else if (req) begin
            seen_hi_r   <= 1'b0;
            quiet_cnt_r <= {CNT_W{1'b0}};
        end else if (wait_en) begin
            if (mem_clk_stall) begin
                seen_hi_r <= 1'b1;
            end else if (!seen_hi_r) begin
                quiet_cnt_r <= quiet_cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_copy_dma.sv
// Word-granular memory copy engine: alternating single-word reads and writes on
// the data memory port, descending when the destination overlaps the source ahead.
module mem_copy_dma
    import dma_pkg::*;
#(
    parameter int LEN_W = 11,
    parameter int WDOG  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       src_addr,
    input  logic [31:0]       dst_addr,
    input  logic [LEN_W-1:0]  len_words,
    output logic              busy,
    output logic              done,
    output logic              err,
    mem_copy_dma_if.master    mem
);

    dma_state_e       state_r;
    dma_state_e       next_state_s;
    logic [31:0]      src_ptr_r;
    logic [31:0]      dst_ptr_r;
    logic [31:0]      data_r;
    logic [LEN_W-1:0] remaining_r;
    logic             descend_r;
    logic             fault_r;

    logic             len_zero_s;
    logic             misalign_s;
    logic [31:0]      span_s;
    logic [31:0]      last_off_s;
    logic             overlap_s;
    logic             issue_en_s;
    logic             wait_en_s;
    logic             req_s;
    logic             complete_s;
    logic             timeout_s;

    // Start-time operand classification
    always_comb begin
        len_zero_s = (len_words == {LEN_W{1'b0}});
        misalign_s = word_misaligned(src_addr) | word_misaligned(dst_addr);
        span_s     = 32'({len_words, 2'b00});
        last_off_s = span_s - WORD_BYTES;
        overlap_s  = (dst_addr > src_addr) && (dst_addr < (src_addr + span_s));
        issue_en_s = (state_r == ST_RD_ISSUE) || (state_r == ST_WR_ISSUE);
        wait_en_s  = (state_r == ST_RD_WAIT)  || (state_r == ST_WR_WAIT);
    end

    mem_port_req #(
        .WDOG (WDOG)
    ) u_req (
        .clk           (clk),
        .reset         (reset),
        .issue_en      (issue_en_s),
        .wait_en       (wait_en_s),
        .mem_clk_stall (mem.mem_clk_stall),
        .req           (req_s),
        .complete      (complete_s),
        .timeout       (timeout_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!start) begin
                    next_state_s = ST_IDLE;
                end else if (len_zero_s || misalign_s) begin
                    next_state_s = ST_FIN;
                end else begin
                    next_state_s = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                if (req_s) begin
                    next_state_s = ST_RD_WAIT;
                end else begin
                    next_state_s = ST_RD_ISSUE;
                end
            end
            ST_RD_WAIT: begin
                if (complete_s) begin
                    next_state_s = ST_WR_ISSUE;
                end else if (timeout_s) begin
                    next_state_s = ST_FIN;
                end else begin
                    next_state_s = ST_RD_WAIT;
                end
            end
            ST_WR_ISSUE: begin
                if (req_s) begin
                    next_state_s = ST_WR_WAIT;
                end else begin
                    next_state_s = ST_WR_ISSUE;
                end
            end
            ST_WR_WAIT: begin
                if (complete_s) begin
                    next_state_s = (remaining_r == LEN_W'(1)) ? ST_FIN : ST_RD_ISSUE;
                end else if (timeout_s) begin
                    next_state_s = ST_FIN;
                end else begin
                    next_state_s = ST_WR_WAIT;
                end
            end
            ST_FIN:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Operand latch, pointer stepping, read-data capture and fault flag
    always_ff @(posedge clk) begin
        if (reset) begin
            src_ptr_r   <= 32'h0000_0000;
            dst_ptr_r   <= 32'h0000_0000;
            data_r      <= 32'h0000_0000;
            remaining_r <= {LEN_W{1'b0}};
            descend_r   <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (len_zero_s) begin
                            fault_r <= 1'b0;
                        end else if (misalign_s) begin
                            fault_r <= 1'b1;
                        end else begin
                            src_ptr_r   <= overlap_s ? (src_addr + last_off_s) : src_addr;
                            dst_ptr_r   <= overlap_s ? (dst_addr + last_off_s) : dst_addr;
                            remaining_r <= len_words;
                            descend_r   <= overlap_s;
                            fault_r     <= 1'b0;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (complete_s) begin
                        data_r <= mem.mem_read_data;
                    end else if (timeout_s) begin
                        fault_r <= 1'b1;
                    end
                end
                ST_WR_WAIT: begin
                    if (complete_s) begin
                        remaining_r <= remaining_r - LEN_W'(1);
                        src_ptr_r   <= ptr_step(src_ptr_r, descend_r);
                        dst_ptr_r   <= ptr_step(dst_ptr_r, descend_r);
                    end else if (timeout_s) begin
                        fault_r <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode; requests only ever assert in an issue state with an idle memory
    always_comb begin
        busy               = (state_r != ST_IDLE) && (state_r != ST_FIN);
        done               = (state_r == ST_FIN);
        err                = (state_r == ST_FIN) && fault_r;
        mem.mem_memread    = (state_r == ST_RD_ISSUE) && req_s;
        mem.mem_memwrite   = (state_r == ST_WR_ISSUE) && req_s;
        mem.mem_sign_mask  = SM_WORD;
        mem.mem_write_data = 32'h0000_0000;
        if ((state_r == ST_RD_ISSUE) || (state_r == ST_RD_WAIT)) begin
            mem.mem_addr = src_ptr_r;
        end else if ((state_r == ST_WR_ISSUE) || (state_r == ST_WR_WAIT)) begin
            mem.mem_addr       = dst_ptr_r;
            mem.mem_write_data = data_r;
        end else begin
            mem.mem_addr = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma with a two-cycle-stall data memory model.
module tb_mem_copy_dma;
    import dma_pkg::*;

    localparam int LEN_W = 11;
    localparam int WDOG  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len_words;
    logic             busy;
    logic             done;
    logic             err;

    mem_copy_dma_if mif ();

    mem_copy_dma #(.LEN_W(LEN_W), .WDOG(WDOG)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len_words (len_words),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem       (mif)
    );

    always #5 clk = ~clk;

    // Memory model: each accepted request holds stall high for two cycles
    logic [31:0] mem_arr [0:1023];
    int          busy_cnt = 0;
    int          rd_count = 0;
    int          wr_count = 0;
    int          viol     = 0;
    logic        prev_req = 1'b0;
    logic        mute = 1'b0;
    logic        force_stall = 1'b0;
    logic        pl_en = 1'b0;
    logic [31:0] pl_addr = 32'h0;
    logic [31:0] pl_data = 32'h0;

    assign mif.mem_clk_stall = (busy_cnt != 0) || force_stall;

    always @(posedge clk) begin
        prev_req <= mif.mem_memread | mif.mem_memwrite;
        if ((mif.mem_memread | mif.mem_memwrite) && prev_req) viol <= viol + 1;
        if (pl_en) mem_arr[pl_addr[11:2]] <= pl_data;
        if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        if (mif.mem_memread || mif.mem_memwrite) begin
            if (mif.mem_clk_stall || (mif.mem_memread && mif.mem_memwrite) ||
                (mif.mem_sign_mask != 4'b0111)) begin
                viol <= viol + 1;
            end else if (mif.mem_memread) begin
                rd_count <= rd_count + 1;
                if (!mute) begin
                    mif.mem_read_data <= mem_arr[mif.mem_addr[11:2]];
                    busy_cnt <= 2;
                end
            end else begin
                wr_count <= wr_count + 1;
                mem_arr[mif.mem_addr[11:2]] <= mif.mem_write_data;
                busy_cnt <= 2;
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    function automatic logic [31:0] mem_at(input logic [31:0] a);
        return mem_arr[a[11:2]];
    endfunction

    int          op_done_k, op_busy, op_first_rd_k, op_rd, op_wr;
    logic        op_err;
    logic [31:0] op_first_rd_addr;
    int          poke_k    = -1;
    int          release_k = -1;

    // One copy request; k counts cycles after the start edge (k=1 is cycle t+1)
    task automatic do_op(input logic [31:0] s, input logic [31:0] d,
                         input logic [LEN_W-1:0] n, input int budget);
        int rd0, wr0, k;
        @(negedge clk);
        src_addr = s; dst_addr = d; len_words = n; start = 1'b1;
        rd0 = rd_count; wr0 = wr_count;
        @(posedge clk); #1 start = 1'b0;
        k = 0; op_done_k = -1; op_err = 1'b0; op_busy = 0;
        op_first_rd_k = -1; op_first_rd_addr = 32'h0;
        while (k < budget) begin
            @(negedge clk);
            k++;
            if (mif.mem_memread && op_first_rd_k < 0) begin
                op_first_rd_k = k; op_first_rd_addr = mif.mem_addr;
            end
            if (busy) op_busy++;
            if (done) begin
                op_done_k = k; op_err = err;
                break;
            end
            if (k == poke_k) begin
                start = 1'b1; src_addr = 32'h600; dst_addr = 32'h700; len_words = LEN_W'(1);
            end else begin
                start = 1'b0;
            end
            if (k == release_k) begin
                @(posedge clk); #1 force_stall = 1'b0;
            end
        end
        start = 1'b0;
        op_rd = rd_count - rd0;
        op_wr = wr_count - wr0;
    endtask

    initial begin
        int done_seen;
        reset = 1'b1; start = 1'b0; src_addr = 32'h0; dst_addr = 32'h0; len_words = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_rd", 32'(mif.mem_memread), 32'd0);
        check_val("rst_wr", 32'(mif.mem_memwrite), 32'd0);
        check_val("rst_addr", mif.mem_addr, 32'h0);
        check_val("rst_mask", 32'(mif.mem_sign_mask), 32'h7);
        reset = 1'b0;

        // Plain 4-word forward copy
        preload(32'h100, 32'h1111_1111); preload(32'h104, 32'h2222_2222);
        preload(32'h108, 32'h3333_3333); preload(32'h10C, 32'h4444_4444);
        do_op(32'h100, 32'h200, LEN_W'(4), 60);
        check_val("fw_done_k", 32'(op_done_k), 32'd33);
        check_val("fw_err", 32'(op_err), 32'd0);
        check_val("fw_busy", 32'(op_busy), 32'd32);
        check_val("fw_first_k", 32'(op_first_rd_k), 32'd1);
        check_val("fw_first_a", op_first_rd_addr, 32'h100);
        check_val("fw_reads", 32'(op_rd), 32'd4);
        check_val("fw_writes", 32'(op_wr), 32'd4);
        check_val("fw_m200", mem_at(32'h200), 32'h1111_1111);
        check_val("fw_m204", mem_at(32'h204), 32'h2222_2222);
        check_val("fw_m208", mem_at(32'h208), 32'h3333_3333);
        check_val("fw_m20C", mem_at(32'h20C), 32'h4444_4444);

        // Forward overlap: descending copy
        preload(32'h100, 32'hAAAA_0001); preload(32'h104, 32'hBBBB_0002);
        preload(32'h108, 32'hCCCC_0003); preload(32'h10C, 32'h0000_0000);
        do_op(32'h100, 32'h104, LEN_W'(3), 60);
        check_val("ov_done_k", 32'(op_done_k), 32'd25);
        check_val("ov_first_a", op_first_rd_addr, 32'h108);
        check_val("ov_m100", mem_at(32'h100), 32'hAAAA_0001);
        check_val("ov_m104", mem_at(32'h104), 32'hAAAA_0001);
        check_val("ov_m108", mem_at(32'h108), 32'hBBBB_0002);
        check_val("ov_m10C", mem_at(32'h10C), 32'hCCCC_0003);

        // Zero length and misaligned requests
        do_op(32'h100, 32'h200, LEN_W'(0), 10);
        check_val("z_done_k", 32'(op_done_k), 32'd1);
        check_val("z_err", 32'(op_err), 32'd0);
        check_val("z_access", 32'(op_rd + op_wr + op_busy), 32'd0);
        do_op(32'h102, 32'h200, LEN_W'(2), 10);
        check_val("ms_done_k", 32'(op_done_k), 32'd1);
        check_val("ms_err", 32'(op_err), 32'd1);
        check_val("ms_access", 32'(op_rd + op_wr + op_busy), 32'd0);
        do_op(32'h100, 32'h201, LEN_W'(2), 10);
        check_val("md_err", 32'(op_err), 32'd1);

        // Watchdog: memory never raises stall after the read
        mute = 1'b1;
        do_op(32'h100, 32'h300, LEN_W'(2), 20);
        mute = 1'b0;
        check_val("wd_done_k", 32'(op_done_k), 32'(WDOG + 2));
        check_val("wd_err", 32'(op_err), 32'd1);
        check_val("wd_busy", 32'(op_busy), 32'(WDOG + 1));
        check_val("wd_writes", 32'(op_wr), 32'd0);

        // Memory still busy at start: read must wait for stall to drop
        force_stall = 1'b1; release_k = 3;
        do_op(32'h100, 32'h180, LEN_W'(1), 30);
        release_k = -1; force_stall = 1'b0;
        check_val("st_first_k", 32'(op_first_rd_k), 32'd4);
        check_val("st_done_k", 32'(op_done_k), 32'd12);
        check_val("st_m180", mem_at(32'h180), 32'hAAAA_0001);

        // start and src_addr disturbed mid-copy
        preload(32'h400, 32'h5555_AAAA); preload(32'h404, 32'h6666_9999);
        preload(32'h600, 32'h1234_5678); preload(32'h700, 32'h0BAD_C0DE);
        poke_k = 5;
        do_op(32'h400, 32'h500, LEN_W'(2), 40);
        poke_k = -1;
        check_val("pk_done_k", 32'(op_done_k), 32'd17);
        check_val("pk_reads", 32'(op_rd), 32'd2);
        check_val("pk_m500", mem_at(32'h500), 32'h5555_AAAA);
        check_val("pk_m504", mem_at(32'h504), 32'h6666_9999);
        check_val("pk_m700", mem_at(32'h700), 32'h0BAD_C0DE);

        // Reset during WR_WAIT of word 2
        preload(32'h100, 32'hD000_0001); preload(32'h104, 32'hD000_0002);
        preload(32'h108, 32'hD000_0003); preload(32'h10C, 32'hD000_0004);
        preload(32'h308, 32'hFFFF_FFFF);
        @(negedge clk);
        src_addr = 32'h100; dst_addr = 32'h300; len_words = LEN_W'(4); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("rr_busy", 32'(busy), 32'd0);
        check_val("rr_done", 32'(done), 32'd0);
        check_val("rr_req", 32'(mif.mem_memread | mif.mem_memwrite), 32'd0);
        check_val("rr_addr", mif.mem_addr, 32'h0);
        check_val("rr_wdata", mif.mem_write_data, 32'h0);
        done_seen = 0;
        for (int i = 0; i < 10 && mif.mem_clk_stall; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check_val("rr_stall_idle", 32'(mif.mem_clk_stall), 32'd0);
        check_val("rr_no_done", 32'(done_seen), 32'd0);
        check_val("rr_m308", mem_at(32'h308), 32'hFFFF_FFFF);
        do_op(32'h100, 32'h300, LEN_W'(4), 60);
        check_val("rr_done_k", 32'(op_done_k), 32'd33);
        check_val("rr_m300", mem_at(32'h300), 32'hD000_0001);
        check_val("rr_m30C", mem_at(32'h30C), 32'hD000_0004);

        check_val("protocol", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_copy_dma.md
# mem_copy_dma

Word-granular copy engine that acts as an initiator on the data memory port (addr / write_data / memwrite / memread / sign_mask / read_data / clk_stall). Given a source address, destination address and word count, it issues alternating single-word reads and writes through that port and honours the clk_stall handshake. It sits beside the core's MEM stage as a second master, with ownership muxed outside this block, and is used for bulk initialisation and buffer moves without CPU load/store loops.

## Interface
Parameters:
- LEN_W, 11: width of the word-count input; 0..1024 words covers the whole 4 KiB data block.
- WDOG, 3: maximum number of cycles after an issue cycle for mem_clk_stall to go high before the operation faults.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_addr  in  32  byte address of the first source word.
- dst_addr  in  32  byte address of the first destination word.
- len_words  in  LEN_W  number of words to copy.
- busy  out  1  high from the first issue until the cycle before done.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, when the operation faulted or was rejected.
- mem_addr  out  32  byte address to the memory.
- mem_write_data  out  32  store data.
- mem_memwrite  out  1  store request, held high for exactly one cycle per word.
- mem_memread  out  1  load request, held high for exactly one cycle per word.
- mem_sign_mask  out  4  always SM_WORD (4'b0111: unsigned full word).
- mem_read_data  in  32  load data; valid in the first cycle mem_clk_stall reads 0 after a read.
- mem_clk_stall  in  1  memory busy; 0 means the memory is idle and accepts a request.

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, FIN.
- IDLE, start=1:
  - If len_words=0: go to FIN with err=0; no memory access.
  - If src_addr[1:0]≠0 or dst_addr[1:0]≠0: go to FIN with err=1; no memory access.
  - Otherwise latch the operands and choose the copy direction.
  - The copy is descending when dst>src and dst<src+4·len (unsigned 32-bit compare, forward overlap). Pointers then start at src+4(len−1) and dst+4(len−1) and step by −4. Otherwise they start at src and dst and step by +4.
  - Pointer arithmetic is modulo 2^32.
- RD_ISSUE: waits while mem_clk_stall=1. When mem_clk_stall=0, drive mem_memread=1 and mem_addr=src_ptr for that single cycle, then go to RD_WAIT.
- RD_WAIT:
  - Set seen_hi when mem_clk_stall=1.
  - When seen_hi is set and mem_clk_stall=0, latch mem_read_data into the data register and go to WR_ISSUE.
  - If mem_clk_stall stays 0 for WDOG cycles with seen_hi clear, set the fault and go to FIN.
- WR_ISSUE / WR_WAIT: identical handshake with mem_memwrite=1, mem_addr=dst_ptr and mem_write_data=data register. On completion:
  - Decrement the remaining-word counter and step both pointers.
  - Go to RD_ISSUE if the counter is nonzero, else FIN.
- FIN: pulse done for one cycle (plus err if faulted), then return to IDLE.
- start while not in IDLE is ignored.
- Operands are latched at start; later input changes have no effect.
- Reset in any state:
  - Returns to IDLE, drops busy, and discards the in-flight word. No done pulse is generated.
  - The memory has no reset and may still be finishing a request. The issue rule (mem_clk_stall=0) guarantees no request is lost after reset.
- Reset values: busy, done, err, mem_memread and mem_memwrite are 0. mem_addr and mem_write_data are 0. mem_sign_mask is 4'b0111.

## Timing
- start is sampled at edge t. With an idle memory, the first mem_memread is high in cycle t+1.
- Each word takes 8 cycles:
  - Read issue in cycle c.
  - mem_clk_stall is high in c+1 and c+2.
  - Read data is captured in c+3.
  - Write issue in c+4.
  - mem_clk_stall is high in c+5 and c+6.
  - Write completes in c+7.
  - The next read issues in c+8.
- N words: done pulses in cycle t+1+8N; busy is high in cycles t+1 .. t+8N.
- Zero-length or misaligned start: done (and err if misaligned) pulses in cycle t+1; busy never rises.
- Requests are never high for two consecutive cycles, so the memory never re-triggers on a held request.

## Structure
- Shared package dma_pkg holds:
  - SM_WORD=4'b0111, SM_HALF, SM_BYTE.
  - The state encoding constants.
  - DATA_BASE and the LED address 32'h2000, so the bench can avoid the LED register.
- One natural sub-module, mem_port_req: the issue / stall-watch / watchdog handshake, instantiated once and shared by the read and write phases.

## Test plan
- Copy 4 words from 0x100 (preloaded 0x11111111..0x44444444) to 0x200 → 0x200..0x20C match, done in cycle t+33, err=0, 4 reads and 4 writes.
- Overlap: src=0x100, dst=0x104, len=3, data A,B,C → 0x104..0x10C = A,B,C and 0x100 = A. Addresses descend: first read at 0x108.
- len_words=0 → done at t+1, err=0, no memread/memwrite. src=0x102 → done and err at t+1, no access.
- Memory model holds mem_clk_stall low after a read issue → err and done after WDOG+1 cycles, busy falls, no write issued.
- Reset asserted in WR_WAIT of word 2 of 4 → outputs return to reset values the next cycle. A new start is issued only after mem_clk_stall=0 and completes correctly.
- start pulsed while busy, and src_addr changed mid-copy → ignored, the original copy completes unchanged.
